// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and the synchronous
// instruction memory (slave).
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] InstrAddr;
  logic              InstrReadEn;
  logic [31:0]       InstrData;

  modport master (
    output InstrAddr,
    output InstrReadEn,
    input  InstrData
  );

  modport slave (
    input  InstrAddr,
    input  InstrReadEn,
    output InstrData
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction
// memory and holds the IF/ID register (PCD/ValidD) with stall, redirect and halt.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'hFC00_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      imem,
  input  logic              StallF,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] PCTarget,
  input  logic              Stuck,
  output logic [31:0]       InstrD,
  output logic [ADDR_W-1:0] PCD,
  output logic              ValidD,
  output logic [5:0]        Opcode,
  output logic [4:0]        Rd,
  output logic [2:0]        Func,
  output logic              Halted
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pcf_q, pcf_d;
  logic [ADDR_W-1:0] pcd_q, pcd_d;
  logic              valid_q, valid_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pcf_q   <= RESET_PC;
      pcd_q   <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      pcd_q   <= pcd_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: redirect > stall > halt > sequential fetch
  always_comb begin
    state_d = state_q;
    pcf_d   = pcf_q;
    pcd_d   = pcd_q;
    valid_d = valid_q;
    case (state_q)
      ST_RUN: begin
        if (PCSrc) begin
          pcf_d   = PCTarget & ALIGN_MASK;
          valid_d = 1'b0;
        end else if (StallF) begin
          pcf_d   = pcf_q;
        end else if (Stuck && valid_q) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else begin
          pcd_d   = pcf_q;
          valid_d = 1'b1;
          pcf_d   = pcf_q + PC_STEP;
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
        valid_d = 1'b0;
      end
    endcase
  end

  // Read enable is gated by rst_n so the memory holds while reset is asserted
  assign imem.InstrAddr   = pcf_q;
  assign imem.InstrReadEn = rst_n && (state_q == ST_RUN) && !StallF;

  assign InstrD = valid_q ? imem.InstrData : NOP_INSTR;
  assign PCD    = pcd_q;
  assign ValidD = valid_q;
  assign Halted = (state_q == ST_HALT);
  assign Opcode = InstrD[31:26];
  assign Rd     = InstrD[25:21];
  assign Func   = InstrD[2:0];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the decode stage's control unit. Owns the program counter, drives the synchronous instruction memory, and presents the fetched instruction and its Opcode/Func/Rd fields to decode as the IF/ID stage. Applies stalls, branch redirects (PCSrc) and the halt request (Stuck) coming back from the rest of the pipeline. Bubbles are NOP_INSTR so the control unit's default case produces no side effects.

## Interface

- ADDR_W, 32, PC / instruction address width
- RESET_PC, 0, PC value loaded on reset
- NOP_INSTR, 32'hFC00_0000, instruction substituted for bubbles (Opcode 111111, control-unit default, no writes)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- InstrAddr  output  ADDR_W  address to instruction memory, equals PCF
- InstrReadEn  output  1  instruction memory read enable; memory output holds when low
- InstrData  input  32  instruction memory output, registered in memory, valid 1 cycle after an enabled read
- StallF  input  1  hazard stall: hold PC and IF/ID
- PCSrc  input  1  redirect request from execute (older instruction)
- PCTarget  input  ADDR_W  redirect target; bits [1:0] ignored, treated as 00
- Stuck  input  1  halt request from control unit for the instruction in decode
- InstrD  output  32  decode-stage instruction: InstrData when ValidD, else NOP_INSTR
- PCD  output  ADDR_W  address of InstrD
- ValidD  output  1  InstrD is a real, non-squashed instruction
- Opcode  output  6  InstrD[31:26]
- Rd  output  5  InstrD[25:21]
- Func  output  3  InstrD[2:0]
- Halted  output  1  high while in HALT

## Operation

- Registers: PCF, PCD, ValidD, state {RUN, HALT}.
- Reset (async, rst_n low): PCF=RESET_PC, PCD=RESET_PC, ValidD=0, state=RUN. Outputs during reset: InstrAddr=RESET_PC, InstrReadEn=0, InstrD=NOP_INSTR, Halted=0.
- InstrReadEn = (state==RUN) && !StallF.
- RUN, per-edge priority (highest first):
  - PCSrc: PCF<=PCTarget with [1:0]=00; ValidD<=0 (squash decode and the wrong-path fetch); Stuck ignored; applies even when StallF.
  - StallF: PCF, PCD, ValidD held; memory output held via InstrReadEn=0; Stuck deferred until stall releases.
  - Stuck && ValidD: state<=HALT, ValidD<=0, PCF held.
  - Otherwise: PCD<=PCF, ValidD<=1, PCF<=PCF+4 modulo 2^ADDR_W.
- HALT: InstrReadEn=0, ValidD=0, Halted=1, PCF/PCD frozen; PCSrc, StallF, Stuck ignored; exit only via rst_n.
- Stuck while ValidD=0 has no effect.
- Field outputs always derive from InstrD, so bubbles decode as Opcode 111111.

## Timing

- Fetch latency: address A with InstrReadEn=1 at cycle n -> InstrD=mem[A], PCD=A, ValidD=1 at cycle n+1.
- Throughput: one instruction per cycle when unstalled.
- First valid instruction: first rising edge after rst_n deasserts issues RESET_PC; ValidD=1 one cycle later.
- Redirect penalty: PCSrc at cycle n -> ValidD=0 at n+1, InstrAddr=PCTarget at n+1, target instruction valid at n+2.
- Stall: outputs bit-identical on every cycle StallF is high (without PCSrc).
- Halt: Stuck with ValidD at cycle n -> Halted=1, ValidD=0 from n+1.
- PC wrap: PCF=2^ADDR_W-4 increments to 0, no flag.
- rst_n asserted mid-operation (including HALT): immediate return to reset values, no edge required.

## Test plan

- Reset then free run, mem[i]=i: InstrAddr 0,4,8,... each cycle; PCD/InstrD lag by one cycle; ValidD=0 only in first post-reset cycle.
- StallF high 3 cycles at PCF=0x10: InstrAddr stays 0x10, InstrReadEn=0, InstrD/PCD=0x0C unchanged; resumes 0x14 after release.
- PCSrc=1, PCTarget=0x43 at PCF=0x20: next cycle InstrAddr=0x40, ValidD=0, Opcode=111111; cycle after PCD=0x40, ValidD=1.
- PCSrc and StallF together, plus PCSrc with Stuck and ValidD: redirect taken, no halt, Halted=0.
- Stuck with ValidD at PCD=0x08: Halted=1, ValidD=0, InstrReadEn=0, PCF frozen at 0x0C for 20 cycles despite PCSrc pulses; rst_n low clears Halted asynchronously.
- ADDR_W=8, RESET_PC=0xF8: InstrAddr 0xF8, 0xFC, 0x00, 0x04.
